run_controller: RTL and testbench
=================================

# run_controller

Execution sequencer for the single-cycle RISC-V CPU. Issues a per-cycle advance enable (`cpu_en_o`) that drives the CPU's `start_i` / PC-update and register-write gating. Accepts RUN, STEP, RUN_N and HALT commands over a valid/ready port. Stops execution on a PC breakpoint, on an all-zero instruction word (end of program), on command-count exhaustion, or on an explicit HALT. Sits between the bench/debug host and the CPU top; it observes `pc_o` and the fetched instruction.

## Interface
Parameters:
- `CNT_W`, 16: width of the RUN_N instruction count.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `cmd_valid_i`  in  1  command strobe.
- `cmd_op_i`  in  2  00 RUN, 01 STEP, 10 HALT, 11 RUN_N.
- `cmd_count_i`  in  CNT_W  instruction count for RUN_N; ignored otherwise.
- `cmd_ready_o`  out  1  command accepted on an edge where `cmd_valid_i & cmd_ready_o`.
- `bp_en_i`  in  1  breakpoint enable.
- `bp_addr_i`  in  32  breakpoint PC.
- `pc_i`  in  32  current CPU PC.
- `instr_i`  in  32  instruction at `pc_i`.
- `cpu_en_o`  out  1  CPU executes one instruction on this edge.
- `busy_o`  out  1  state is RUN or RUN_N.
- `halt_cause_o`  out  3  000 none, 001 count done, 010 HALT cmd, 011 breakpoint, 100 zero instruction.
- `retired_o`  out  32  instructions executed (edges with `cpu_en_o`=1).

## Operation
- States: IDLE, RUN (unbounded), RUN_N (bounded; STEP = RUN_N with count 1).
- `cmd_ready_o`:
  - IDLE: 1 for any op.
  - RUN / RUN_N: 1 only when `cmd_op_i`=HALT. Other ops are held off, not dropped.
- Accepting commands in IDLE:
  - RUN: go to RUN.
  - STEP: go to RUN_N with remaining=1.
  - RUN_N: go to RUN_N with remaining=`cmd_count_i`.
  - HALT: stay IDLE, `halt_cause_o`←010.
  - On RUN/STEP/RUN_N acceptance, `halt_cause_o`←000 and `first`←1.
- RUN_N with count 0: go straight to IDLE, cause 001. No `cpu_en_o` is issued.
- In RUN / RUN_N, stop conditions are evaluated each cycle. Priority: zero instruction (`instr_i`==0) > breakpoint (`bp_en_i & pc_i==bp_addr_i & !first`) > HALT command accepted this cycle.
- If any stop condition is true: `cpu_en_o`=0, next state IDLE, cause set to the winning code.
- Otherwise `cpu_en_o`=1:
  - `retired_o` increments (wraps mod 2^32).
  - `first`←0.
  - In RUN_N, remaining decrements. If remaining was 1, next state IDLE with cause 001.
- The breakpoint is suppressed for the first instruction of every command, so RUN issued while sitting on a breakpoint makes progress.
- `cpu_en_o` is combinational from state, `first`, `pc_i`, `instr_i`, `bp_*` and the HALT command. It is never asserted in IDLE.

## Timing
- Reset (edge with `rst_i`=1), regardless of state: state IDLE, `cpu_en_o`=0, `busy_o`=0, `cmd_ready_o`=1, `halt_cause_o`=000, `retired_o`=0, remaining=0, `first`=0. Reset mid-run aborts with no further enables.
- A command accepted at edge T gives state RUN/RUN_N from T+1. The first `cpu_en_o` appears in cycle T+1, so the first PC advance is at edge T+2.
- RUN_N count=N with no other stop: exactly N consecutive cycles of `cpu_en_o`=1, then IDLE on the edge of the Nth enable. The next command is accepted no earlier than that edge +1.
- HALT during RUN has zero-cycle effect: in the cycle it is presented, `cpu_en_o`=0 and no retire occurs; IDLE follows the next edge.
- Stop cause is visible on `halt_cause_o` from the edge that enters IDLE, and is held until the next RUN/STEP/RUN_N acceptance.
- `pc_i` and `instr_i` must reflect the post-edge PC within the same cycle (single-cycle CPU).

## Test plan
- Reset, then STEP ×3 with program `addi` ×3, then zeros → three single-cycle `cpu_en_o` pulses; PC 0→4→8→12; `retired_o`=3; cause 001 after each step.
- RUN_N count=5 → exactly 5 consecutive enables; PC ends at 20; `busy_o` falls at the edge of the 5th enable; `cmd_ready_o`=0 for RUN presented mid-run.
- RUN with breakpoint 16 → stops with PC=16, `retired_o`=4, cause 011. A second RUN executes PC 16 (breakpoint suppressed) and continues.
- RUN into zero word at PC 28 → stops at PC=28, `retired_o`=7, cause 100, no enable in the stop cycle.
- HALT presented 3 cycles into RUN → that cycle `cpu_en_o`=0; IDLE next edge; cause 010; `retired_o`=2.
- `rst_i` pulsed mid RUN_N count=10 → from the reset edge, `cpu_en_o`=0, `retired_o`=0, cause 000, state IDLE. RUN_N count=0 afterwards → IDLE with cause 001 and no enable.

Source files
------------

// File: rtl/run_controller.sv
// Purpose : execution sequencer issuing a per-cycle advance enable to a single-cycle CPU.
// Latency : command accepted at edge T gives the first cpu_en_o in cycle T+1; stops take effect in the cycle they are seen.
// Backpres: cmd_ready_o is high in IDLE for any op; while running only HALT is accepted, other ops wait.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   cmd_valid_i/_op_i/_count_i, cmd_ready_o   command port (00 RUN, 01 STEP, 10 HALT, 11 RUN_N)
//   bp_en_i, bp_addr_i     PC breakpoint
//   pc_i, instr_i          current PC and instruction word fetched from it
//   cpu_en_o               CPU executes one instruction on the coming edge
//   busy_o                 running (RUN or RUN_N)
//   halt_cause_o           000 none, 001 count done, 010 HALT, 011 breakpoint, 100 zero instruction
//   retired_o              count of edges with cpu_en_o high (wraps)
module run_controller #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   input  logic [1:0]       cmd_op_i,
   input  logic [CNT_W-1:0] cmd_count_i,
   output logic             cmd_ready_o,
   input  logic             bp_en_i,
   input  logic [31:0]      bp_addr_i,
   input  logic [31:0]      pc_i,
   input  logic [31:0]      instr_i,
   output logic             cpu_en_o,
   output logic             busy_o,
   output logic [2:0]       halt_cause_o,
   output logic [31:0]      retired_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_RUN_N = 2'd2
   } state_t;

   localparam logic [1:0] OP_RUN   = 2'b00;
   localparam logic [1:0] OP_STEP  = 2'b01;
   localparam logic [1:0] OP_HALT  = 2'b10;
   localparam logic [1:0] OP_RUN_N = 2'b11;

   localparam logic [2:0] CAUSE_NONE  = 3'b000;
   localparam logic [2:0] CAUSE_COUNT = 3'b001;
   localparam logic [2:0] CAUSE_HALT  = 3'b010;
   localparam logic [2:0] CAUSE_BP    = 3'b011;
   localparam logic [2:0] CAUSE_ZERO  = 3'b100;

   state_t           state, state_n;
   logic [CNT_W-1:0] remaining, remaining_n;
   logic             first, first_n;
   logic [2:0]       cause, cause_n;
   logic [31:0]      retired, retired_n;
   logic             cpu_en;
   logic             accept;
   logic             stop_zero;
   logic             stop_bp;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         remaining <= '0;
         first     <= 1'b0;
         cause     <= CAUSE_NONE;
         retired   <= '0;
      end else begin
         state     <= state_n;
         remaining <= remaining_n;
         first     <= first_n;
         cause     <= cause_n;
         retired   <= retired_n;
      end
   end

   // While running only HALT may be taken; any other op stays pending on the port.
   assign cmd_ready_o = (state == ST_IDLE) || (cmd_op_i == OP_HALT);
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign stop_zero   = (instr_i == 32'h0);
   // The first instruction of a command ignores the breakpoint so a resume can leave it.
   assign stop_bp     = bp_en_i && (pc_i == bp_addr_i) && !first;

   always_comb begin
      state_n     = state;
      remaining_n = remaining;
      first_n     = first;
      cause_n     = cause;
      retired_n   = retired;
      cpu_en      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (cmd_op_i)
                  OP_RUN: begin
                     state_n = ST_RUN;
                     cause_n = CAUSE_NONE;
                     first_n = 1'b1;
                  end
                  OP_STEP: begin
                     state_n     = ST_RUN_N;
                     remaining_n = CNT_W'(1);
                     cause_n     = CAUSE_NONE;
                     first_n     = 1'b1;
                  end
                  OP_RUN_N: begin
                     first_n = 1'b1;
                     if (cmd_count_i == '0) begin
                        // Nothing to execute: complete immediately without leaving IDLE.
                        cause_n = CAUSE_COUNT;
                     end else begin
                        state_n     = ST_RUN_N;
                        remaining_n = cmd_count_i;
                        cause_n     = CAUSE_NONE;
                     end
                  end
                  default: begin
                     cause_n = CAUSE_HALT;
                  end
               endcase
            end
         end
         default: begin
            if (stop_zero) begin
               state_n = ST_IDLE;
               cause_n = CAUSE_ZERO;
            end else if (stop_bp) begin
               state_n = ST_IDLE;
               cause_n = CAUSE_BP;
            end else if (accept) begin
               // Only HALT can be accepted here.
               state_n = ST_IDLE;
               cause_n = CAUSE_HALT;
            end else begin
               cpu_en    = 1'b1;
               retired_n = retired + 32'd1;
               first_n   = 1'b0;
               if (state == ST_RUN_N) begin
                  remaining_n = remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     state_n = ST_IDLE;
                     cause_n = CAUSE_COUNT;
                  end
               end
            end
         end
      endcase
   end

   assign cpu_en_o     = cpu_en;
   assign busy_o       = (state != ST_IDLE);
   assign halt_cause_o = cause;
   assign retired_o    = retired;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a small PC model advances by 4 on every enabled edge
// and fetches from an 8-word program whose word at PC 28 is zero.
module tb_run_controller;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic [1:0]  cmd_op_i = 2'b00;
   logic [15:0] cmd_count_i = 16'd0;
   logic        cmd_ready_o;
   logic        bp_en_i = 1'b0;
   logic [31:0] bp_addr_i = 32'h0;
   logic [31:0] pc_i;
   logic [31:0] instr_i;
   logic        cpu_en_o;
   logic        busy_o;
   logic [2:0]  halt_cause_o;
   logic [31:0] retired_o;

   int total = 0;
   int bad   = 0;

   logic [31:0] prog [0:7];
   logic [31:0] pc;

   run_controller #(.CNT_W(16)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_op_i     (cmd_op_i),
      .cmd_count_i  (cmd_count_i),
      .cmd_ready_o  (cmd_ready_o),
      .bp_en_i      (bp_en_i),
      .bp_addr_i    (bp_addr_i),
      .pc_i         (pc_i),
      .instr_i      (instr_i),
      .cpu_en_o     (cpu_en_o),
      .busy_o       (busy_o),
      .halt_cause_o (halt_cause_o),
      .retired_o    (retired_o)
   );

   always #5 clk_i = ~clk_i;

   // Single-cycle CPU stand-in.
   always @(posedge clk_i) begin
      if (rst_i)         pc <= 32'h0;
      else if (cpu_en_o) pc <= pc + 32'd4;
   end
   assign pc_i    = pc;
   assign instr_i = (pc < 32'd32) ? prog[pc[4:2]] : 32'h0;

   localparam logic [1:0] RUN = 2'b00, STEP = 2'b01, HALT = 2'b10, RUNN = 2'b11;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] cnt;
      int          exp_en;
      logic [2:0]  exp_cause;
   } vec_t;

   vec_t vecs [0:7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // Present a command for one edge; in IDLE it is accepted on that edge.
   task automatic issue(input logic [1:0] op, input logic [15:0] cnt);
      @(negedge clk_i);
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_count_i = cnt;
      @(posedge clk_i);
      #1;
      cmd_valid_i = 1'b0;
   endtask

   task automatic run_until_idle(input string nm, input int maxc, output int ens);
      int c;
      ens = 0;
      for (c = 0; c < maxc; c++) begin
         @(negedge clk_i);
         if (cpu_en_o) ens++;
         if (!busy_o) break;
      end
      total++;
      if (c >= maxc) begin
         bad++;
         $display("FAIL %s: still busy after %0d cycles, expected idle", nm, maxc);
      end
   endtask

   initial begin
      int ens;
      int c;
      for (int i = 0; i < 7; i++) prog[i] = 32'h00108093;  // addi x1,x1,1
      prog[7] = 32'h0;

      //          op    cnt        enables cause
      vecs[0] = '{STEP, 16'd0,     1,      3'b001};
      vecs[1] = '{RUNN, 16'd3,     3,      3'b001};
      vecs[2] = '{RUNN, 16'd0,     0,      3'b001};
      vecs[3] = '{HALT, 16'd0,     0,      3'b010};
      vecs[4] = '{RUN,  16'd0,     7,      3'b100};
      vecs[5] = '{RUNN, 16'd7,     7,      3'b001};
      vecs[6] = '{RUNN, 16'd8,     7,      3'b100};
      vecs[7] = '{RUNN, 16'hFFFF,  7,      3'b100};

      // Reset state
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      chk("rst_cpu_en", 32'(cpu_en_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_ready", 32'(cmd_ready_o), 32'd1);
      chk("rst_cause", 32'(halt_cause_o), 32'd0);
      chk("rst_retired", retired_o, 32'd0);

      // Table: one command from a fresh reset, then observe 20 cycles.
      for (int v = 0; v < 8; v++) begin
         do_reset();
         issue(vecs[v].op, vecs[v].cnt);
         ens = 0;
         repeat (20) begin
            @(negedge clk_i);
            if (cpu_en_o) ens++;
         end
         chk($sformatf("vec%0d_enables", v), 32'(ens), 32'(vecs[v].exp_en));
         chk($sformatf("vec%0d_cause", v), 32'(halt_cause_o), 32'(vecs[v].exp_cause));
         chk($sformatf("vec%0d_retired", v), retired_o, 32'(vecs[v].exp_en));
         chk($sformatf("vec%0d_busy", v), 32'(busy_o), 32'd0);
      end

      // STEP x3
      do_reset();
      for (int s = 0; s < 3; s++) begin
         issue(STEP, 16'd0);
         @(negedge clk_i);
         chk($sformatf("step%0d_en", s), 32'(cpu_en_o), 32'd1);
         @(negedge clk_i);
         chk($sformatf("step%0d_en_off", s), 32'(cpu_en_o), 32'd0);
         chk($sformatf("step%0d_cause", s), 32'(halt_cause_o), 32'd1);
         chk($sformatf("step%0d_pc", s), pc, 32'(4 * (s + 1)));
      end
      chk("step_retired", retired_o, 32'd3);

      // RUN_N 5 with a RUN held off mid-run
      do_reset();
      issue(RUNN, 16'd5);
      ens = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         if (cpu_en_o) ens++;
         if (k == 2) begin
            cmd_valid_i = 1'b1;
            cmd_op_i    = RUN;
            #1;
            chk("runn_ready_mid", 32'(cmd_ready_o), 32'd0);
            cmd_valid_i = 1'b0;
         end
         if (k == 4) chk("runn_busy_5th", 32'(busy_o), 32'd1);
      end
      chk("runn_enables", 32'(ens), 32'd5);
      @(negedge clk_i);
      chk("runn_busy_after", 32'(busy_o), 32'd0);
      chk("runn_en_after", 32'(cpu_en_o), 32'd0);
      chk("runn_pc", pc, 32'd20);
      chk("runn_retired", retired_o, 32'd5);
      chk("runn_cause", 32'(halt_cause_o), 32'd1);

      // Breakpoint at 16, then resume into the zero word
      do_reset();
      bp_en_i   = 1'b1;
      bp_addr_i = 32'd16;
      issue(RUN, 16'd0);
      run_until_idle("bp_wait", 40, ens);
      chk("bp_enables", 32'(ens), 32'd4);
      chk("bp_pc", pc, 32'd16);
      chk("bp_retired", retired_o, 32'd4);
      chk("bp_cause", 32'(halt_cause_o), 32'd3);
      issue(RUN, 16'd0);
      chk("resume_cause_clr", 32'(halt_cause_o), 32'd0);
      @(negedge clk_i);
      chk("resume_en_on_bp", 32'(cpu_en_o), 32'd1);
      for (c = 0; c < 20; c++) begin
         @(negedge clk_i);
         if (pc == 32'd28) break;
      end
      chk("zero_reached", 32'(c < 20), 32'd1);
      chk("zero_stop_en", 32'(cpu_en_o), 32'd0);
      chk("zero_stop_busy", 32'(busy_o), 32'd1);
      @(negedge clk_i);
      chk("zero_busy", 32'(busy_o), 32'd0);
      chk("zero_pc", pc, 32'd28);
      chk("zero_retired", retired_o, 32'd7);
      chk("zero_cause", 32'(halt_cause_o), 32'd4);
      bp_en_i = 1'b0;

      // HALT three cycles into RUN
      do_reset();
      issue(RUN, 16'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      @(negedge clk_i);
      cmd_valid_i = 1'b1;
      cmd_op_i    = HALT;
      #1;
      chk("halt_ready", 32'(cmd_ready_o), 32'd1);
      chk("halt_en", 32'(cpu_en_o), 32'd0);
      @(posedge clk_i);
      #1;
      cmd_valid_i = 1'b0;
      @(negedge clk_i);
      chk("halt_busy", 32'(busy_o), 32'd0);
      chk("halt_cause", 32'(halt_cause_o), 32'd2);
      chk("halt_retired", retired_o, 32'd2);
      chk("halt_pc", pc, 32'd8);

      // Reset mid RUN_N 10, then RUN_N 0
      do_reset();
      issue(RUNN, 16'd10);
      repeat (3) @(negedge clk_i);
      chk("mid_en_before", 32'(cpu_en_o), 32'd1);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("mid_rst_en", 32'(cpu_en_o), 32'd0);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_retired", retired_o, 32'd0);
      chk("mid_rst_cause", 32'(halt_cause_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      issue(RUNN, 16'd0);
      ens = 0;
      repeat (3) begin
         @(negedge clk_i);
         if (cpu_en_o) ens++;
      end
      chk("cnt0_enables", 32'(ens), 32'd0);
      chk("cnt0_cause", 32'(halt_cause_o), 32'd1);
      chk("cnt0_busy", 32'(busy_o), 32'd0);
      chk("cnt0_retired", retired_o, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
